mmio_store_capture: RTL and testbench
=====================================

Name: mmio_store_capture

Overview:
- Listens on the MIPS data-memory write port (`memwrite`, `dataadr`, `writedata`) as a hardware consumer of CPU stores.
- Stores whose address falls in a configurable MMIO window are queued in a FIFO. A host drains them over a valid/ready interface.
- Independently raises a sticky `halt` flag when the CPU stores the program-completion value to the completion address.
- Sits beside the data memory in `top`. The CPU is unaware of it.

Parameters:
- DEPTH, 8, FIFO entries; power of two, ≥2.
- WIN_BASE, 32'h0000_0040, MMIO window base address.
- WIN_MASK, 32'hFFFF_FFC0, mask applied to `dataadr` before comparing with WIN_BASE.
- HALT_ADDR, 32'd84, completion store address.
- HALT_DATA, 32'd5, completion store value.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous reset, active-low (clears state on the rising `clk` edge while `reset`==0).
- memwrite  in  1  CPU store strobe.
- dataadr  in  32  CPU store byte address.
- writedata  in  32  CPU store data.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  host accepts head.
- out_addr  out  32  head entry address.
- out_data  out  32  head entry data.
- count  out  $clog2(DEPTH+1)  current occupancy.
- overflow  out  1  sticky: a store was dropped because the FIFO was full.
- halt  out  1  sticky: completion store seen.

Behaviour:
- Reset (`reset`==0 at clk edge): pointers=0, count=0, out_valid=0, overflow=0, halt=0. `out_addr`/`out_data` are don't-care while out_valid=0.
- Reset mid-operation discards all queued entries. Stores presented during the reset cycle are ignored.
- hit = memwrite && ((dataadr & WIN_MASK) == WIN_BASE).
- push = hit && (count<DEPTH || pop).
- pop = out_valid && out_ready.
- Show-ahead FIFO: out_valid = (count!=0). Head fields are driven combinationally from storage.
- Push latency: a store captured at edge N is visible at the head after edge N when the FIFO was empty.
- Simultaneous push and pop:
  - count unchanged; both pointers advance.
  - When full, the pop frees the slot and the push is accepted.
  - When empty, only the push is effective; pop is impossible since out_valid=0.
- Full, hit, no pop: store dropped, overflow←1. overflow stays set until reset.
- out_ready while out_valid=0: no effect.
- Pointers are log2(DEPTH) bits wide and wrap naturally. count is separate and saturates logically at DEPTH, never DEPTH+1.
- halt←1 when memwrite && dataadr==HALT_ADDR && writedata==HALT_DATA.
  - Evaluated independently of the window and of FIFO fullness.
  - Sticky until reset.
  - A completion store that is also in the window is additionally queued.
- X on memwrite during reset is tolerated. After reset, inputs are required to be known.

Optional Feature:
- Macro STORE_DROP_COUNT_EN.
- Defined: adds output `drop_count` [15:0].
  - Increments on every dropped store and saturates at 16'hFFFF.
  - Reset to 0.
- Undefined: port and counter absent. overflow flag only.

Decomposition:
- Shared package mips_mmio_pkg:
  - WORD_W=32.
  - Default WIN_BASE/WIN_MASK and HALT_ADDR/HALT_DATA constants.
  - typedef store_entry_t {addr[31:0], data[31:0]}.
- One sub-module, `sync_fifo`: parameterised width/depth, show-ahead, push/pop/count/full/empty.
- mmio_store_capture holds the window decode, halt detect, overflow and drop logic.

Test Plan:
- Reset held low 3 cycles with memwrite=1 at 0x40 -> count=0, out_valid=0, halt=0 after release.
- Store 0x40←0xAAAA5555, out_ready=0 -> next cycle out_valid=1, out_addr=0x40, out_data=0xAAAA5555, count=1.
- 9 consecutive window stores (0x40..0x60, data 1..9), out_ready=0 -> count=8, overflow=1, drain order yields data 1..8. With STORE_DROP_COUNT_EN: drop_count=1.
- FIFO full, then store data 0x77 with out_ready=1 in the same cycle -> count stays 8, overflow stays 0, last drained entry is 0x77.
- Store 84←4, then 80←5, then 84←5 -> halt rises only after the third store and stays 1 during 10 idle cycles. The window hit at 84 is queued.
- Store to 0x100 (outside window) -> count unchanged, out_valid unchanged, halt unchanged.

Source files
------------

// File: rtl/mips_mmio_pkg.sv
// Shared definitions for the MIPS store-capture slice: word width, default
// window/completion constants and the queued store entry layout.
// No logic; imported by the interface, the FIFO user and the top.
package mips_mmio_pkg;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] DEF_WIN_BASE  = 32'h0000_0040;
    localparam logic [WORD_W-1:0] DEF_WIN_MASK  = 32'hFFFF_FFC0;
    localparam logic [WORD_W-1:0] DEF_HALT_ADDR = 32'd84;
    localparam logic [WORD_W-1:0] DEF_HALT_DATA = 32'd5;

    typedef struct packed {
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } store_entry_t;

endpackage

// File: rtl/mmio_store_capture_if.sv
// Bus bundle for the store-capture block: CPU store port in, host drain port out.
// master = CPU/host side (drives store strobe and out_ready), slave = capture block.
// Drain side is valid/ready; the store side has no backpressure.
interface mmio_store_capture_if;
    import mips_mmio_pkg::*;

    logic              memwrite;
    logic [WORD_W-1:0] dataadr;
    logic [WORD_W-1:0] writedata;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_addr;
    logic [WORD_W-1:0] out_data;

    modport master (
        output memwrite, dataadr, writedata, out_ready,
        input  out_valid, out_addr, out_data
    );

    modport slave (
        input  memwrite, dataadr, writedata, out_ready,
        output out_valid, out_addr, out_data
    );

endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO, power-of-two DEPTH, separate occupancy counter.
// Latency: a push at edge N is visible on rdata after edge N when empty.
// Backpressure: push ignored when full unless popping the same cycle; pop ignored when empty.
// Ports: clk, reset (sync, active-low), push/wdata, pop/rdata, count, full, empty.
module sync_fifo #(
    parameter  int W     = 64,
    parameter  int DEPTH = 8,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop_ok, push_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign rdata = mem_q[rptr_q];

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Pointers wrap on their own because DEPTH is a power of two.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_ok) wptr_d = wptr_q + PW'(1);
        if (pop_ok)  rptr_d = rptr_q + PW'(1);
        if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
        else if (pop_ok && !push_ok) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: nothing is readable until the pointers say so.
    always_ff @(posedge clk) begin
        if (reset && push_ok) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/mmio_store_capture.sv
// Snoops CPU stores: queues those inside the MMIO window, flags the completion store.
// Latency: a captured store is at the FIFO head one edge after the store cycle.
// Backpressure: none toward the CPU; stores hitting a full FIFO are dropped (sticky overflow).
// Ports: clk, reset (sync, active-low), bus (store in / drain out), count, overflow, halt,
//        drop_count when STORE_DROP_COUNT_EN is defined (saturating 16-bit drop counter).
module mmio_store_capture
    import mips_mmio_pkg::*;
#(
    parameter  int                DEPTH     = 8,
    parameter  logic [WORD_W-1:0] WIN_BASE  = DEF_WIN_BASE,
    parameter  logic [WORD_W-1:0] WIN_MASK  = DEF_WIN_MASK,
    parameter  logic [WORD_W-1:0] HALT_ADDR = DEF_HALT_ADDR,
    parameter  logic [WORD_W-1:0] HALT_DATA = DEF_HALT_DATA,
    localparam int                CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    mmio_store_capture_if.slave   bus,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  halt
`ifdef STORE_DROP_COUNT_EN
    ,
    output logic [15:0]           drop_count
`endif
);

    store_entry_t wr_entry, head_entry;
    logic         hit, push, pop, drop, halt_hit;
    logic         full, empty;
    logic         overflow_q, halt_q;

    assign hit      = bus.memwrite && ((bus.dataadr & WIN_MASK) == WIN_BASE);
    assign pop      = !empty && bus.out_ready;
    assign push     = hit && (!full || pop);
    assign drop     = hit && full && !pop;
    // Completion detect ignores the window and FIFO state entirely.
    assign halt_hit = bus.memwrite && (bus.dataadr == HALT_ADDR) && (bus.writedata == HALT_DATA);

    assign wr_entry = '{addr: bus.dataadr, data: bus.writedata};

    sync_fifo #(
        .W     ($bits(store_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (wr_entry),
        .pop   (pop),
        .rdata (head_entry),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign bus.out_valid = !empty;
    assign bus.out_addr  = head_entry.addr;
    assign bus.out_data  = head_entry.data;

    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow_q <= 1'b0;
            halt_q     <= 1'b0;
        end else begin
            if (drop)     overflow_q <= 1'b1;
            if (halt_hit) halt_q     <= 1'b1;
        end
    end

    assign overflow = overflow_q;
    assign halt     = halt_q;

`ifdef STORE_DROP_COUNT_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            drop_cnt_q <= '0;
        end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_mmio_store_capture.sv
// Self-checking bench: directed scenarios then random stores against a queue-based model.
// The driver updates the model at each edge; a negedge monitor compares DUT outputs.
module tb_mmio_store_capture;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    logic          clk;
    logic          reset;
    logic [CW-1:0] count;
    logic          overflow;
    logic          halt;
`ifdef STORE_DROP_COUNT_EN
    logic [15:0]   drop_count;
`endif

    mmio_store_capture_if bus();

    mmio_store_capture #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .count      (count),
        .overflow   (overflow),
        .halt       (halt)
`ifdef STORE_DROP_COUNT_EN
        ,
        .drop_count (drop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ent_t        exp_q[$];
    bit          mdl_ovf;
    bit          mdl_halt;
    int          mdl_drops;
    int          total;
    int          bad;
    logic [31:0] last_dat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One store cycle. Model rules: window is [0x40,0x80); a full queue takes a
    // store only if the head leaves in the same cycle; otherwise it is dropped.
    task automatic drive(input logic mw, input logic [31:0] a, input logic [31:0] d, input logic rdy);
        int occ;
        bit pop_m, hit_m, push_m;
        bus.memwrite  = mw;
        bus.dataadr   = a;
        bus.writedata = d;
        bus.out_ready = rdy;
        occ    = exp_q.size();
        pop_m  = (occ > 0) && rdy;
        hit_m  = mw && (a >= 32'h40) && (a < 32'h80);
        push_m = hit_m && ((occ < DEPTH) || pop_m);
        @(posedge clk);
        if (push_m) exp_q.push_back('{a: a, d: d});
        if (hit_m && !push_m) begin
            mdl_ovf = 1'b1;
            if (mdl_drops < 65535) mdl_drops++;
        end
        if (mw && (a == 32'd84) && (d == 32'd5)) mdl_halt = 1'b1;
        #1;
    endtask

    task automatic do_reset(input int n, input logic [31:0] a, input logic [31:0] d);
        reset         = 1'b0;
        bus.memwrite  = 1'b1;
        bus.dataadr   = a;
        bus.writedata = d;
        bus.out_ready = 1'b1;
        repeat (n) @(posedge clk);
        exp_q.delete();
        mdl_ovf   = 1'b0;
        mdl_halt  = 1'b0;
        mdl_drops = 0;
        #1;
        reset         = 1'b1;
        bus.memwrite  = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            drive(1'b0, 32'h0, 32'h0, 1'b1);
            n++;
        end
        check("drain_timeout_left", 32'(exp_q.size()), 32'd0);
    endtask

    function automatic logic [31:0] pick_addr(input int k);
        case (k)
            0:       return 32'h40;
            1:       return 32'h44;
            2:       return 32'h5C;
            3:       return 32'h7C;
            4:       return 32'd84;
            5:       return 32'd80;
            6:       return 32'h100;
            7:       return 32'h3C;
            8:       return 32'h80;
            default: return 32'h0;
        endcase
    endfunction

    // Monitor: compares visible state with the model and retires entries on handshake.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
                check("count", 32'(count), 32'(exp_q.size()));
                check("overflow", 32'(overflow), 32'(mdl_ovf));
                check("halt", 32'(halt), 32'(mdl_halt));
`ifdef STORE_DROP_COUNT_EN
                check("drop_count", 32'(drop_count), 32'(mdl_drops));
`endif
                if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1 && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("head_addr", bus.out_addr, e.a);
                    check("head_data", bus.out_data, e.d);
                    last_dat = bus.out_data;
                end
            end
        end
    end

    initial begin
        bit          mw;
        bit          rdy;
        logic [31:0] a;
        logic [31:0] d;
        int          pct;

        total     = 0;
        bad       = 0;
        mdl_ovf   = 1'b0;
        mdl_halt  = 1'b0;
        mdl_drops = 0;
        last_dat  = '0;
        reset     = 1'b0;
        bus.memwrite  = 1'bx;
        bus.dataadr   = '0;
        bus.writedata = '0;
        bus.out_ready = 1'b0;

        // Reset held 3 cycles with a window store on the bus: nothing captured.
        do_reset(3, 32'h40, 32'hAAAA_5555);
        check("rst_count", 32'(count), 32'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_halt", 32'(halt), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);

        // Single store appears at the head one edge later.
        drive(1'b1, 32'h40, 32'hAAAA_5555, 1'b0);
        check("t2_valid", 32'(bus.out_valid), 32'd1);
        check("t2_addr", bus.out_addr, 32'h40);
        check("t2_data", bus.out_data, 32'hAAAA_5555);
        check("t2_count", 32'(count), 32'd1);
        drain(4);

        // Nine stores into an 8-deep queue: last one dropped.
        do_reset(1, 32'h40, 32'h1);
        for (int i = 0; i < 9; i++) drive(1'b1, 32'(32'h40 + 4 * i), 32'(i + 1), 1'b0);
        check("t3_count", 32'(count), 32'd8);
        check("t3_overflow", 32'(overflow), 32'd1);
`ifdef STORE_DROP_COUNT_EN
        check("t3_drop_count", 32'(drop_count), 32'd1);
`endif
        drain(20);
        check("t3_last", last_dat, 32'd8);

        // Full queue, store with simultaneous pop: accepted, no overflow.
        do_reset(1, 32'h40, 32'h1);
        for (int i = 0; i < 8; i++) drive(1'b1, 32'(32'h40 + 4 * i), 32'(i + 1), 1'b0);
        drive(1'b1, 32'h60, 32'h77, 1'b1);
        check("t4_count", 32'(count), 32'd8);
        check("t4_overflow", 32'(overflow), 32'd0);
        drain(20);
        check("t4_last", last_dat, 32'h77);

        // Completion store detection.
        do_reset(1, 32'h40, 32'h1);
        drive(1'b1, 32'd84, 32'd4, 1'b0);
        check("t5_halt_a", 32'(halt), 32'd0);
        drive(1'b1, 32'd80, 32'd5, 1'b0);
        check("t5_halt_b", 32'(halt), 32'd0);
        drive(1'b1, 32'd84, 32'd5, 1'b0);
        check("t5_halt_c", 32'(halt), 32'd1);
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b0);
            check("t5_halt_idle", 32'(halt), 32'd1);
        end
        check("t5_count", 32'(count), 32'd3);

        // Out-of-window store leaves everything alone.
        drive(1'b1, 32'h100, 32'h1234, 1'b0);
        check("t6_count", 32'(count), 32'd3);
        check("t6_valid", 32'(bus.out_valid), 32'd1);
        check("t6_halt", 32'(halt), 32'd1);
        drain(10);
        check("t5_last", last_dat, 32'd5);

        // Random traffic with alternating drain pressure and one mid-run reset.
        do_reset(1, 32'h40, 32'h1);
        for (int it = 0; it < 2000; it++) begin
            if (it == 1000) begin
                do_reset(2, 32'd84, 32'd5);
                check("rnd_rst_halt", 32'(halt), 32'd0);
                check("rnd_rst_count", 32'(count), 32'd0);
            end
            pct = ((it % 400) < 200) ? 25 : 75;
            mw  = ($urandom_range(0, 9) < 6);
            a   = pick_addr($urandom_range(0, 9));
            d   = ($urandom_range(0, 3) == 0) ? 32'd5 : 32'($urandom);
            rdy = ($urandom_range(0, 99) < pct);
            drive(mw, a, d, rdy);
        end
        drain(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
